alu_arbiter: RTL and testbench

Shares the single combinational ALU between two requesters, e.g. port 0 = execute stage, port 1 = address/CSR sequencer. Round-robin (or fixed-priority) arbitration accepts at most one operation per cycle, evaluates it in the ALU and returns the result and flags through a one-entry registered response buffer per port. Valid/ready handshakes are used on both sides, and the block keeps a saturating contention counter for performance monitoring.

---
 rtl/alu_arbiter_pkg.sv | 33 +++
 rtl/alu_arbiter_alu.sv | 42 ++++
 rtl/alu_arbiter.sv | 118 +++++++++++
 tb/tb_alu_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-port ALU arbiter: select codes, the
// response-buffer payload and a legality helper.
package alu_arbiter_pkg;

  localparam int XLEN  = 32;
  localparam int NPORT = 2;
  localparam int OP_W  = 4;
  localparam int FLG_W = 3;

  localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
  localparam logic [OP_W-1:0] OP_XOR  = 4'd2;
  localparam logic [OP_W-1:0] OP_OR   = 4'd3;
  localparam logic [OP_W-1:0] OP_AND  = 4'd4;
  localparam logic [OP_W-1:0] OP_SLL  = 4'd5;
  localparam logic [OP_W-1:0] OP_SRL  = 4'd6;
  localparam logic [OP_W-1:0] OP_SRA  = 4'd7;
  localparam logic [OP_W-1:0] OP_SLT  = 4'd8;
  localparam logic [OP_W-1:0] OP_SLTU = 4'd9;
  localparam logic [OP_W-1:0] ALU_OP_MAX = OP_SLTU;

  // Flags are packed {lt_unsigned, lt_signed, zero}.
  typedef struct packed {
    logic [XLEN-1:0]  result;
    logic [FLG_W-1:0] flags;
    logic             err;
  } rsp_t;

  function automatic logic op_is_legal(input logic [OP_W-1:0] op);
    return op <= ALU_OP_MAX;
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Single-stage combinational ALU. Comparison flags always reflect a vs b;
// the zero flag reflects the produced result (0 for illegal selects).
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [OP_W-1:0] op_i,
  output rsp_t            rsp_o
);

  logic [4:0]      shamt;
  logic            lt_s;
  logic            lt_u;
  logic [XLEN-1:0] result;

  assign shamt = b_i[4:0];
  assign lt_s  = $signed(a_i) < $signed(b_i);
  assign lt_u  = a_i < b_i;

  always_comb begin
    result = '0;
    case (op_i)
      OP_ADD:  result = a_i + b_i;
      OP_SUB:  result = a_i - b_i;
      OP_XOR:  result = a_i ^ b_i;
      OP_OR:   result = a_i | b_i;
      OP_AND:  result = a_i & b_i;
      OP_SLL:  result = a_i << shamt;
      OP_SRL:  result = a_i >> shamt;
      OP_SRA:  result = $unsigned($signed(a_i) >>> shamt);
      OP_SLT:  result = {{(XLEN-1){1'b0}}, lt_s};
      OP_SLTU: result = {{(XLEN-1){1'b0}}, lt_u};
      default: result = '0;
    endcase
  end

  assign rsp_o.result = result;
  assign rsp_o.flags  = {lt_u, lt_s, (result == '0)};
  assign rsp_o.err    = ~op_is_legal(op_i);

endmodule

// File: rtl/alu_arbiter.sv
// Two-port arbiter sharing one combinational ALU, with a one-entry registered
// response buffer per port and a saturating contention counter.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned FAIR  = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NPORT-1:0]        req_valid,
  output logic [NPORT-1:0]        req_ready,
  input  logic [NPORT*XLEN-1:0]   req_a,
  input  logic [NPORT*XLEN-1:0]   req_b,
  input  logic [NPORT*OP_W-1:0]   req_op,
  output logic [NPORT-1:0]        rsp_valid,
  input  logic [NPORT-1:0]        rsp_ready,
  output logic [NPORT*XLEN-1:0]   rsp_result,
  output logic [NPORT*FLG_W-1:0]  rsp_flags,
  output logic [NPORT-1:0]        rsp_err,
  output logic [CNT_W-1:0]        contention_cnt
);

  logic [NPORT-1:0] elig;
  logic [NPORT-1:0] grant;
  logic             sel;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  alu_a, alu_b;
  logic [OP_W-1:0]  alu_op;
  rsp_t             alu_rsp;
  logic [NPORT-1:0] rsp_valid_q, rsp_valid_d;
  rsp_t             rsp_q [NPORT];
  rsp_t             rsp_d [NPORT];

  // A full buffer that is not draining blocks only its own port.
  assign elig = req_valid & (~rsp_valid_q | rsp_ready);

  always_comb begin
    grant = '0;
    case (elig)
      2'b01: grant = 2'b01;
      2'b10: grant = 2'b10;
      2'b11: begin
        if (FAIR != 0) grant = last_grant_q ? 2'b01 : 2'b10;
        else           grant = 2'b01;
      end
      default: grant = '0;
    endcase
  end

  assign req_ready = grant;
  assign sel       = grant[1];

  assign alu_a  = sel ? req_a[XLEN +: XLEN]  : req_a[0 +: XLEN];
  assign alu_b  = sel ? req_b[XLEN +: XLEN]  : req_b[0 +: XLEN];
  assign alu_op = sel ? req_op[OP_W +: OP_W] : req_op[0 +: OP_W];

  alu_arbiter_alu u_alu (
    .a_i   (alu_a),
    .b_i   (alu_b),
    .op_i  (alu_op),
    .rsp_o (alu_rsp)
  );

  assign last_grant_d = (|grant) ? sel : last_grant_q;

  always_comb begin
    cnt_d = cnt_q;
    if (|(req_valid & ~grant) && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NPORT; gi++) begin : g_port
      // A same-edge accept overrides the drain so the buffer stays full.
      always_comb begin
        rsp_valid_d[gi] = rsp_valid_q[gi];
        rsp_d[gi]       = rsp_q[gi];
        if (grant[gi]) begin
          rsp_valid_d[gi] = 1'b1;
          rsp_d[gi]       = alu_rsp;
        end else if (rsp_ready[gi]) begin
          rsp_valid_d[gi] = 1'b0;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rsp_valid_q[gi] <= 1'b0;
          rsp_q[gi]       <= '0;
        end else begin
          rsp_valid_q[gi] <= rsp_valid_d[gi];
          rsp_q[gi]       <= rsp_d[gi];
        end
      end

      assign rsp_result[gi*XLEN +: XLEN]  = rsp_q[gi].result;
      assign rsp_flags[gi*FLG_W +: FLG_W] = rsp_q[gi].flags;
      assign rsp_err[gi]                  = rsp_q[gi].err;
    end
  endgenerate

  assign rsp_valid      = rsp_valid_q;
  assign contention_cnt = cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a round-robin instance with a 16-bit counter
// and a fixed-priority instance with a 4-bit counter share clock and reset.
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
  logic [63:0] req_a, req_b, rsp_result;
  logic [7:0]  req_op;
  logic [5:0]  rsp_flags;
  logic [15:0] cnt;

  logic [1:0]  fp_req_valid, fp_req_ready, fp_rsp_valid, fp_rsp_ready, fp_rsp_err;
  logic [63:0] fp_req_a, fp_req_b, fp_rsp_result;
  logic [7:0]  fp_req_op;
  logic [5:0]  fp_rsp_flags;
  logic [3:0]  fp_cnt;

  alu_arbiter #(.FAIR(1), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .contention_cnt(cnt)
  );

  alu_arbiter #(.FAIR(0), .CNT_W(4)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req_valid(fp_req_valid), .req_ready(fp_req_ready),
    .req_a(fp_req_a), .req_b(fp_req_b), .req_op(fp_req_op),
    .rsp_valid(fp_rsp_valid), .rsp_ready(fp_rsp_ready),
    .rsp_result(fp_rsp_result), .rsp_flags(fp_rsp_flags), .rsp_err(fp_rsp_err),
    .contention_cnt(fp_cnt)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
    $display("t=%0t rr: rsp_valid=%b cnt=%0d | fp: rsp_valid=%b cnt=%0d",
             $time, rsp_valid, cnt, fp_rsp_valid, fp_cnt);
  endtask

  task automatic set_req(input int p, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op);
    req_a[32*p +: 32] = a;
    req_b[32*p +: 32] = b;
    req_op[4*p +: 4]  = op;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  logic [1:0] exp_g;

  initial begin
    req_valid = '0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = '0;
    fp_req_valid = '0; fp_req_a = '0; fp_req_b = '0; fp_req_op = '0; fp_rsp_ready = '0;

    // Reset state
    #12;
    chk("rst_valid",  rsp_valid,  0);
    chk("rst_result", rsp_result, 0);
    chk("rst_flags",  rsp_flags,  0);
    chk("rst_err",    rsp_err,    0);
    chk("rst_cnt",    cnt,        0);
    rst_n = 1'b1;

    // Fixed priority: port 1 starves, 4-bit counter saturates at 15
    fp_req_a = {32'd9, 32'd2}; fp_req_b = {32'd1, 32'd3}; fp_req_op = {4'd1, 4'd0};
    fp_req_valid = 2'b11; fp_rsp_ready = 2'b11;
    for (int k = 1; k <= 20; k++) begin
      #1;
      chk("fp_grant", fp_req_ready, 2'b01);
      edge1();
      if (k == 14) chk("fp_cnt14", fp_cnt, 14);
    end
    chk("fp_cnt_sat", fp_cnt, 15);
    chk("fp_valid",   fp_rsp_valid, 2'b01);
    chk("fp_result0", fp_rsp_result[31:0], 32'd5);
    fp_req_valid = 2'b00;

    // Single op: 5 - 7
    set_req(0, 32'd5, 32'd7, 4'd1);
    req_valid = 2'b01; rsp_ready = 2'b11;
    #1;
    chk("single_ready", req_ready, 2'b01);
    edge1();
    req_valid = 2'b00;
    chk("single_valid",  rsp_valid[0],      1'b1);
    chk("single_result", rsp_result[31:0],  32'hFFFF_FFFE);
    chk("single_flags",  rsp_flags[2:0],    3'b110);
    chk("single_err",    rsp_err[0],        1'b0);
    chk("single_cnt",    cnt,               0);

    // Round-robin: port 0 was last granted, so port 1 goes first
    set_req(0, 32'd10, 32'd3, 4'd0);
    set_req(1, 32'd20, 32'd6, 4'd2);
    req_valid = 2'b11;
    exp_g = 2'b10;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_grant", req_ready, exp_g);
      edge1();
      chk("rr_valid", rsp_valid, exp_g);
      chk("rr_cnt",   cnt, 64'(k + 1));
      exp_g = ~exp_g;
    end
    chk("rr_result0", rsp_result[31:0],  32'd13);
    chk("rr_result1", rsp_result[63:32], 32'h12);

    // Backpressure on port 0; port 1 keeps completing
    rsp_ready = 2'b10;
    set_req(0, 32'd100, 32'd1, 4'd1);
    set_req(1, 32'd1, 32'd2, 4'd0);
    req_valid = 2'b11;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_grant", req_ready, 2'b10);
      edge1();
      chk("bp_valid",   rsp_valid, 2'b11);
      chk("bp_result1", rsp_result[63:32], 32'd3);
      chk("bp_hold0",   rsp_result[31:0], 32'd13);
      chk("bp_cnt",     cnt, 64'(k + 5));
    end

    // Same-edge drain and accept on port 0
    req_valid = 2'b01; rsp_ready = 2'b11;
    #1;
    chk("sda_grant", req_ready, 2'b01);
    edge1();
    chk("sda_valid",  rsp_valid, 2'b01);
    chk("sda_result", rsp_result[31:0], 32'd99);
    chk("sda_flags",  rsp_flags[2:0], 3'b000);
    chk("sda_cnt",    cnt, 9);
    set_req(0, 32'd1, 32'd31, 4'd5);
    #1;
    chk("sll_grant", req_ready, 2'b01);
    edge1();
    req_valid = 2'b00;
    chk("sll_valid",  rsp_valid[0], 1'b1);
    chk("sll_result", rsp_result[31:0], 32'h8000_0000);
    chk("sll_flags",  rsp_flags[2:0], 3'b110);

    // Errors: op 12 on port 1, then boundary ops 9 and 10 on port 0
    set_req(1, 32'd3, 32'd3, 4'd12);
    req_valid = 2'b10;
    #1;
    chk("err_grant", req_ready, 2'b10);
    edge1();
    req_valid = 2'b00;
    chk("err_flag",   rsp_err, 2'b10);
    chk("err_result", rsp_result[63:32], 32'd0);
    chk("err_flags",  rsp_flags[5:3], 3'b001);
    set_req(0, 32'd1, 32'd2, 4'd9);
    req_valid = 2'b01;
    edge1();
    chk("sltu_result", rsp_result[31:0], 32'd1);
    chk("sltu_err",    rsp_err[0], 1'b0);
    chk("sltu_flags",  rsp_flags[2:0], 3'b110);
    set_req(0, 32'd0, 32'd0, 4'd10);
    edge1();
    req_valid = 2'b00;
    chk("op10_result", rsp_result[31:0], 32'd0);
    chk("op10_err",    rsp_err[0], 1'b1);
    chk("op10_flags",  rsp_flags[2:0], 3'b001);

    // Reset with both responses pending
    rsp_ready = 2'b00;
    set_req(0, 32'd1, 32'd1, 4'd0);
    set_req(1, 32'd2, 32'd2, 4'd0);
    req_valid = 2'b11;
    edge1();
    edge1();
    req_valid = 2'b00;
    chk("pend_valid", rsp_valid, 2'b11);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid",  rsp_valid,  0);
    chk("arst_result", rsp_result, 0);
    chk("arst_flags",  rsp_flags,  0);
    chk("arst_err",    rsp_err,    0);
    chk("arst_cnt",    cnt,        0);
    #2;
    rst_n = 1'b1;
    req_valid = 2'b11; rsp_ready = 2'b11;
    #1;
    chk("post_rst_grant", req_ready, 2'b01);
    edge1();
    chk("post_rst_valid0", rsp_valid, 2'b01);
    chk("post_rst_grant2", req_ready, 2'b10);
    edge1();
    req_valid = 2'b00;
    chk("post_rst_valid1", rsp_valid, 2'b10);
    chk("post_rst_result", rsp_result[63:32], 32'd4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
